// File: rtl/regfile_scoreboard.sv
// Integer register file with combinational read ports, write-to-read bypass and a
// per-register busy scoreboard used by issue (reserve) and writeback (clear).
module regfile_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGISTERS  = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 1,
  localparam int IDX_W = $clog2(NUM_REGISTERS),
  localparam int CNT_W = $clog2(NUM_REGISTERS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_READ_PORTS*IDX_W-1:0]      rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_ready,
  input  logic                                 wr_en,
  input  logic [IDX_W-1:0]                     wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 rsv_en,
  input  logic [IDX_W-1:0]                     rsv_addr,
  output logic                                 rsv_ok,
  output logic [CNT_W-1:0]                     busy_count
);

  logic [DATA_WIDTH-1:0]    data_q [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic wr_take, rsv_take, cnt_inc, cnt_dec;

  function automatic logic in_range(input logic [IDX_W-1:0] a);
    return (32'(a) < 32'(NUM_REGISTERS));
  endfunction

  // Writable: exists and is not the hardwired zero register.
  function automatic logic writable(input logic [IDX_W-1:0] a);
    return in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic busy_at(input logic [IDX_W-1:0] a);
    return in_range(a) ? busy_q[a] : 1'b0;
  endfunction

  assign wr_take  = wr_en && writable(wr_addr);
  assign rsv_ok   = rsv_en && (!busy_at(rsv_addr) || (wr_en && (wr_addr == rsv_addr)));
  assign rsv_take = rsv_ok && writable(rsv_addr);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
      logic [IDX_W-1:0] addr;
      logic             hit;
      assign addr = rd_addr[gi*IDX_W +: IDX_W];
      assign hit  = wr_take && (wr_addr == addr);
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        hit ? wr_data : (writable(addr) ? data_q[addr] : '0);
      assign rd_ready[gi] = hit || !busy_at(addr);
    end

    // A same-cycle re-reservation wins over the clearing writeback (new owner).
    for (gi = 0; gi < NUM_REGISTERS; gi++) begin : g_busy
      assign busy_d[gi] = (rsv_take && (rsv_addr == IDX_W'(gi))) ? 1'b1 :
                          (wr_take && (wr_addr == IDX_W'(gi)))   ? 1'b0 :
                          busy_q[gi];
    end
  endgenerate

  assign cnt_inc = rsv_take && !busy_at(rsv_addr);
  assign cnt_dec = wr_take && busy_at(wr_addr) && !(rsv_take && (rsv_addr == wr_addr));

  always_comb begin
    count_d = count_q;
    if (cnt_inc && !cnt_dec) begin
      count_d = count_q + CNT_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
        data_q[r] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_take) begin
        data_q[wr_addr] <= wr_data;
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of the register file scoreboard followed by a short issue/writeback
// soak against a small reference model.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int IW = 5;
  localparam int CW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP*IW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_ready;
  logic            wr_en;
  logic [IW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rsv_en;
  logic [IW-1:0]   rsv_addr;
  logic            rsv_ok;
  logic [CW-1:0]   busy_count;

  int n_cmp = 0;
  int n_mis = 0;

  regfile_scoreboard #(
    .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ_PORTS(NP), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_rd(input logic [IW-1:0] a0, input logic [IW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  logic [DW-1:0] m_data [NR];
  logic [NR-1:0] m_busy;

  initial begin
    idle();
    set_rd(0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;

    // 1: reset state on every register, both ports
    for (int r = 0; r < NR; r++) begin
      set_rd(IW'(r), IW'(NR - 1 - r));
      #1;
      check_val($sformatf("rst_data_r%0d", r), rd_data, 64'h0);
      check_val($sformatf("rst_ready_r%0d", r), rd_ready, 64'h3);
    end
    check_val("rst_count", busy_count, 64'd0);
    tick();

    // 2: write bypass then stored value
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(5, 5);
    #2;
    check_val("byp_p0", rd_data[31:0], 64'hDEADBEEF);
    check_val("byp_p1", rd_data[63:32], 64'hDEADBEEF);
    tick();
    idle();
    #2;
    check_val("stored_r5", rd_data[31:0], 64'hDEADBEEF);
    tick();

    // 3: reserve, WAW stall, writeback clears
    rsv_en = 1'b1; rsv_addr = 7; set_rd(7, 5);
    #2;
    check_val("rsv7_ok", rsv_ok, 64'd1);
    tick();
    idle();
    #2;
    check_val("r7_not_ready", rd_ready, 64'b10);
    check_val("count_1", busy_count, 64'd1);
    rsv_en = 1'b1; rsv_addr = 7;
    #1;
    check_val("rsv7_waw", rsv_ok, 64'd0);
    tick();
    idle();
    #2;
    check_val("count_still_1", busy_count, 64'd1);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h42;
    #1;
    check_val("r7_wb_ready", rd_ready[0], 64'd1);
    check_val("r7_wb_data", rd_data[31:0], 64'h42);
    tick();
    idle();
    #2;
    check_val("count_0_after_wb", busy_count, 64'd0);
    check_val("r7_ready_after", rd_ready[0], 64'd1);

    // 4: write and re-reserve same register in one cycle
    rsv_en = 1'b1; rsv_addr = 3; set_rd(3, 7);
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'd9; rsv_en = 1'b1; rsv_addr = 3;
    #2;
    check_val("rsv3_rewrite_ok", rsv_ok, 64'd1);
    tick();
    idle();
    #2;
    check_val("r3_data", rd_data[31:0], 64'd9);
    check_val("r3_still_busy", rd_ready[0], 64'd0);
    check_val("count_r3", busy_count, 64'd1);
    // write to busy r3 plus reserve of r10: net count unchanged
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'd10; rsv_en = 1'b1; rsv_addr = 10; set_rd(3, 10);
    tick();
    idle();
    #2;
    check_val("count_swap", busy_count, 64'd1);
    check_val("swap_ready", rd_ready, 64'b01);
    wr_en = 1'b1; wr_addr = 10; wr_data = 32'h1;
    tick();
    idle();
    #2;
    check_val("count_back_0", busy_count, 64'd0);

    // 5: zero register
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF; rsv_en = 1'b1; rsv_addr = 0; set_rd(0, 0);
    #2;
    check_val("r0_rsv_ok", rsv_ok, 64'd1);
    check_val("r0_no_bypass", rd_data, 64'h0);
    check_val("r0_ready", rd_ready, 64'h3);
    tick();
    idle();
    #2;
    check_val("r0_after", rd_data[31:0], 64'h0);
    check_val("r0_count", busy_count, 64'd0);

    // 6: reservations discarded by reset
    wr_en = 1'b1; wr_addr = 1; wr_data = 32'h11;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      rsv_en = 1'b1; rsv_addr = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd4;
      tick();
    end
    idle();
    #2;
    check_val("count_3", busy_count, 64'd3);
    rst = 1'b1;
    tick();
    idle();
    set_rd(1, 4);
    #2;
    check_val("post_rst_count", busy_count, 64'd0);
    check_val("post_rst_ready", rd_ready, 64'h3);
    check_val("post_rst_r1", rd_data[31:0], 64'h0);

    // soak against model
    for (int r = 0; r < NR; r++) m_data[r] = '0;
    m_busy = '0;
    for (int c = 0; c < 300; c++) begin
      logic [IW-1:0] a0, a1, wa, ra;
      logic we, re, wwr, ok;
      logic [DW-1:0] wd;
      a0 = IW'($urandom_range(0, 7)); a1 = IW'($urandom_range(0, 7));
      wa = IW'($urandom_range(0, 7)); ra = IW'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
      wd = $urandom;
      wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra; set_rd(a0, a1);
      #2;
      wwr = we && (wa != 0);
      ok  = re && (!m_busy[ra] || (we && wa == ra));
      check_val("soak_rsv_ok", rsv_ok, 64'(ok));
      check_val("soak_count", busy_count, 64'($countones(m_busy)));
      check_val("soak_d0", rd_data[31:0], (wwr && wa == a0) ? 64'(wd) : 64'(m_data[a0]));
      check_val("soak_d1", rd_data[63:32], (wwr && wa == a1) ? 64'(wd) : 64'(m_data[a1]));
      check_val("soak_r0", rd_ready[0], 64'((wwr && wa == a0) || !m_busy[a0]));
      check_val("soak_r1", rd_ready[1], 64'((wwr && wa == a1) || !m_busy[a1]));
      if (wwr) begin
        m_data[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (ok && ra != 0) m_busy[ra] = 1'b1;
      tick();
    end
    idle();
    #2;
    check_val("soak_final_count", busy_count, 64'($countones(m_busy)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
